mult_fu: RTL

//  Pipelined integer multiply functional unit: the consumer end of the issue->FU interface.
//  - Accepts MULT_PACKETs from issue and drives backpressure (mult_free) back to it.
//  - Requests the CDB one cycle ahead of writeback (mult_cdb_req), obeys mult_cdb_gnt.
//  - Presents the result plus the destination phys reg tag to the CDB / complete logic.

---
 rtl/mult_fu_pkg.sv | 43 ++++
 rtl/mult_stage.sv | 21 ++
 rtl/mult_fu.sv | 102 ++++++++++
 3 files changed

// File: rtl/mult_fu_pkg.sv
// Shared types for the multiply functional unit: issue packet, CDB result and per-stage state.
package mult_fu_pkg;

  localparam int unsigned NUM_FU_MULT = 1;

  typedef logic [31:0] DATA;
  typedef logic [5:0]  PHYS_REG_IDX;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } MULT_FUNC;

  typedef struct packed {
    logic        valid;
    DATA         source_reg_1;
    DATA         source_reg_2;
    MULT_FUNC    mult_func;
    PHYS_REG_IDX dest_reg_idx;
  } MULT_PACKET;

  typedef struct packed {
    logic        valid;
    PHYS_REG_IDX dest_reg_idx;
    DATA         result;
  } MULT_RESULT;

  typedef struct packed {
    logic        valid;
    PHYS_REG_IDX dest_reg_idx;
    MULT_FUNC    mult_func;
    logic [63:0] mcand;
    logic [63:0] mplier;
    logic [63:0] prod;
  } MULT_STAGE_PACKET;

  function automatic logic [63:0] ext64(DATA v, logic sgn);
    return sgn ? {{32{v[31]}}, v} : {32'b0, v};
  endfunction

endpackage

// File: rtl/mult_stage.sv
// One partial-product step: folds the low ChunkBits of the multiplier into the running product.
module mult_stage
  import mult_fu_pkg::*;
#(
  parameter int unsigned ChunkBits = 16
) (
  input  MULT_STAGE_PACKET stage_i,
  output MULT_STAGE_PACKET stage_o
);

  logic [63:0] mplier_chunk;

  always_comb begin
    mplier_chunk    = 64'(stage_i.mplier[ChunkBits-1:0]);
    stage_o         = stage_i;
    stage_o.prod    = stage_i.prod + stage_i.mcand * mplier_chunk;
    stage_o.mcand   = stage_i.mcand << ChunkBits;
    stage_o.mplier  = stage_i.mplier >> ChunkBits;
  end

endmodule

// File: rtl/mult_fu.sv
// Pipelined multiply FU with CDB request/grant backpressure; NUM_STAGES in {2, 4, 8}.
// Defining MULT_SQUASH_EN adds a squash input that drops every op in flight.
module mult_fu
  import mult_fu_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4
) (
  input  logic       clock,
  input  logic       reset,
`ifdef MULT_SQUASH_EN
  input  logic       squash,
`endif
  input  MULT_PACKET mult_packet,
  input  logic       mult_cdb_gnt,
  output logic       mult_free,
  output logic       mult_cdb_req,
  output MULT_RESULT mult_result
);

  localparam int unsigned ChunkBits = 64 / NUM_STAGES;

  MULT_STAGE_PACKET entry;
  MULT_STAGE_PACKET stage_in  [NUM_STAGES];
  MULT_STAGE_PACKET stage_out [NUM_STAGES];
  MULT_STAGE_PACKET stage_q   [NUM_STAGES];
  MULT_STAGE_PACKET stage_d   [NUM_STAGES];
  logic             stall;
  logic             flush;

`ifdef MULT_SQUASH_EN
  assign flush = squash;
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    entry              = '0;
    entry.valid        = mult_packet.valid;
    entry.dest_reg_idx = mult_packet.dest_reg_idx;
    entry.mult_func    = mult_packet.mult_func;
    entry.mcand        = ext64(mult_packet.source_reg_1,
                               (mult_packet.mult_func == MULH) ||
                               (mult_packet.mult_func == MULHSU));
    entry.mplier       = ext64(mult_packet.source_reg_2, mult_packet.mult_func == MULH);
  end

  // Chunk 0 is folded in ahead of the stage-0 register.
  always_comb begin
    stage_in[0] = entry;
    for (int unsigned i = 1; i < NUM_STAGES; i++) begin
      stage_in[i] = stage_q[i-1];
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    mult_stage #(
      .ChunkBits(ChunkBits)
    ) u_stage (
      .stage_i(stage_in[g]),
      .stage_o(stage_out[g])
    );
  end

  assign mult_cdb_req = stage_q[NUM_STAGES-2].valid;
  assign stall        = mult_cdb_req & ~mult_cdb_gnt;
  assign mult_free    = ~stall;

  // The last stage is the result register; it drops its valid on a stall so a
  // result is never presented for two cycles.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        stage_d[i].valid = 1'b0;
      end
    end else if (stall) begin
      stage_d[NUM_STAGES-1].valid = 1'b0;
    end else begin
      stage_d = stage_out;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  always_comb begin
    mult_result              = '0;
    mult_result.valid        = stage_q[NUM_STAGES-1].valid;
    mult_result.dest_reg_idx = stage_q[NUM_STAGES-1].dest_reg_idx;
    mult_result.result       = (stage_q[NUM_STAGES-1].mult_func == MUL) ?
                               stage_q[NUM_STAGES-1].prod[31:0] :
                               stage_q[NUM_STAGES-1].prod[63:32];
  end

endmodule
